div_datapath: RTL

- Datapath counterpart of the divider `controller` FSM.
- Consumes the controller's control word: load, add, sel, shift, inbit, valid.
- Returns `sign`, the sign of the partial remainder, which steers the controller's restore/non-restore decisions.
- Holds divisor, dividend/quotient and partial-remainder registers, and latches the final quotient and remainder when `valid` is asserted.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_datapath_if.sv | 34 +++
 rtl/div_addsub.sv | 18 +
 rtl/div_datapath.sv | 107 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Constants shared by the divider controller and datapath: the remainder-register
// update select encoding and the default operand width.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    SEL_HOLD    = 2'b00,
    SEL_ALU     = 2'b01,
    SEL_RESTORE = 2'b10,
    SEL_DONE    = 2'b11
  } sel_e;

endpackage

// File: rtl/div_datapath_if.sv
// Control word from the divider controller plus the datapath's status/result
// returns. The controller drives the master side and the datapath is the slave.
interface div_datapath_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic [WIDTH-1:0] dividend_in;
  logic [WIDTH-1:0] divisor_in;
  logic             load;
  logic             add;
  logic [1:0]       sel;
  logic             shift;
  logic             inbit;
  logic             valid;
  logic             sign;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             result_valid;
  logic             div_by_zero;
  logic             ctrl_err;

  modport master (
    output dividend_in, divisor_in, load, add, sel, shift, inbit, valid,
    input  sign, quotient, remainder, result_valid, div_by_zero, ctrl_err
  );

  modport slave (
    input  dividend_in, divisor_in, load, add, sel, shift, inbit, valid,
    output sign, quotient, remainder, result_valid, div_by_zero, ctrl_err
  );

endinterface

// File: rtl/div_addsub.sv
// WIDTH+1-bit add/subtract of the partial remainder and the zero-extended divisor.
module div_addsub
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] m,
  input  logic             add,
  output logic [WIDTH:0]   sum_c
);

  logic [WIDTH:0] m_ext;

  assign m_ext = {1'b0, m};
  assign sum_c = add ? (a + m_ext) : (a - m_ext);

endmodule

// File: rtl/div_datapath.sv
// Divider datapath: divisor, dividend/quotient and signed partial-remainder
// registers stepped by the controller's control word, plus latched results.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  div_datapath_if.slave bus
);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             result_valid_q, result_valid_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             ctrl_err_q, ctrl_err_d;

  sel_e             sel_c;
  logic             alu_add_c;
  logic [WIDTH:0]   alu_sum_c;
  logic             conflict_c;

  assign sel_c     = sel_e'(bus.sel);
  // Restore always adds, whatever the controller left on add
  assign alu_add_c = (sel_c == SEL_RESTORE) ? 1'b1 : bus.add;
  assign conflict_c = (bus.load && bus.shift) ||
                      (bus.shift && ((sel_c == SEL_ALU) || (sel_c == SEL_RESTORE)));

  div_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a_q),
    .m     (m_q),
    .add   (alu_add_c),
    .sum_c (alu_sum_c)
  );

  // Next-state: load > shift > sel for the working registers
  always_comb begin
    m_d            = m_q;
    q_d            = q_q;
    a_d            = a_q;
    quotient_d     = quotient_q;
    remainder_d    = remainder_q;
    result_valid_d = bus.valid;
    div_by_zero_d  = div_by_zero_q;
    ctrl_err_d     = ctrl_err_q;

    if (bus.load) begin
      m_d           = bus.divisor_in;
      q_d           = bus.dividend_in;
      a_d           = '0;
      div_by_zero_d = (bus.divisor_in == '0);
      ctrl_err_d    = 1'b0;
    end else if (bus.shift) begin
      a_d = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      q_d = {q_q[WIDTH-2:0], bus.inbit};
    end else begin
      case (sel_c)
        SEL_ALU, SEL_RESTORE: a_d = alu_sum_c;
        default:              a_d = a_q;
      endcase
    end

    // Results capture the registers as they stood before this edge
    if (bus.valid) begin
      quotient_d  = q_q;
      remainder_d = a_q[WIDTH-1:0];
    end

    if (conflict_c) begin
      ctrl_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q            <= '0;
      q_q            <= '0;
      a_q            <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
      ctrl_err_q     <= 1'b0;
    end else begin
      m_q            <= m_d;
      q_q            <= q_d;
      a_q            <= a_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      result_valid_q <= result_valid_d;
      div_by_zero_q  <= div_by_zero_d;
      ctrl_err_q     <= ctrl_err_d;
    end
  end

  assign bus.sign         = a_q[WIDTH];
  assign bus.quotient     = quotient_q;
  assign bus.remainder    = remainder_q;
  assign bus.result_valid = result_valid_q;
  assign bus.div_by_zero  = div_by_zero_q;
  assign bus.ctrl_err     = ctrl_err_q;

endmodule
